// File: rtl/updown_counter_mod.sv
// Generic up/down counter: modulus, wrap or saturate, load, clear, flags.
// Define UPDOWN_COUNTER_SNAPSHOT_EN to add the snap/snap_count capture port.
module updown_counter_mod #(
  parameter int WIDTH       = 8,
  parameter int MODULUS     = 256,
  parameter int SATURATE    = 0,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             clear,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             flag_clr,
`ifdef UPDOWN_COUNTER_SNAPSHOT_EN
  input  logic             snap,
  output logic [WIDTH-1:0] snap_count,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf,
  output logic             unf
);

  localparam int W1 = WIDTH + 1;
  localparam logic [WIDTH:0] MOD_X = W1'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);
  localparam bit SAT = (SATURATE != 0);

  generate
    if (WIDTH < 2)
      $error("WIDTH must be at least 2");
    if (MODULUS < 2 || MODULUS > (2 ** WIDTH))
      $error("MODULUS out of range");
    if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS)
      $error("RESET_VALUE must be below MODULUS");
  endgenerate

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH:0] cnt_x;
  logic [WIDTH:0] inc_x;
  logic [WIDTH:0] dec_x;
  logic [WIDTH:0] ld_x;
  logic           at_max;
  logic           at_min;
  logic           ld_ok;
  logic           up_evt;
  logic           dn_evt;
  logic           lim_evt;

  // One extra bit: carry-out of inc hits MOD_X, borrow-out flags zero.
  assign cnt_x  = {1'b0, count_q};
  assign inc_x  = cnt_x + W1'(1);
  assign dec_x  = cnt_x - W1'(1);
  assign ld_x   = {1'b0, load_value};
  assign at_max = (inc_x == MOD_X);
  assign at_min = dec_x[WIDTH];
  assign ld_ok  = (ld_x < MOD_X);

  assign up_evt  = en & up & at_max;
  assign dn_evt  = en & ~up & at_min;
  assign lim_evt = (up_evt | dn_evt)
                 & ~clear & ~load;

  assign tc = up_evt | dn_evt;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = RST_V;
    end else if (load) begin
      count_d = ld_ok ? load_value : MAX_V;
    end else if (en) begin
      wrap_d = tc;
      if (up) begin
        if (at_max)
          count_d = SAT ? count_q : '0;
        else
          count_d = inc_x[WIDTH-1:0];
      end else begin
        if (at_min)
          count_d = SAT ? count_q : MAX_V;
        else
          count_d = dec_x[WIDTH-1:0];
      end
    end
  end

  // A limit event outranks flag_clr in the same cycle.
  assign ovf_d = (lim_evt & up)
               | (ovf_q & ~flag_clr);
  assign unf_d = (lim_evt & ~up)
               | (unf_q & ~flag_clr);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      count_q <= RST_V;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

`ifdef UPDOWN_COUNTER_SNAPSHOT_EN
  logic [WIDTH-1:0] snap_q, snap_d;

  assign snap_d = snap ? count_q : snap_q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)
      snap_q <= '0;
    else
      snap_q <= snap_d;
  end

  assign snap_count = snap_q;
`endif

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench: wrapping and saturating instances driven in parallel,
// checked every cycle against an arithmetic model plus literal pins.
module tb_updown_counter_mod;

  localparam int W   = 4;
  localparam int MOD = 10;

  logic         clk;
  logic         resetb;
  logic         clear;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_value;
  logic         flag_clr;
  logic         snap;

  logic [W-1:0] d_cnt [2];
  logic         d_tc  [2];
  logic         d_wrap[2];
  logic         d_ovf [2];
  logic         d_unf [2];
`ifdef UPDOWN_COUNTER_SNAPSHOT_EN
  logic [W-1:0] d_snap[2];
`endif

  int  errors = 0;
  int  checks = 0;
  bit  chk_on = 0;

  int  m_cnt [2];
  bit  m_wrap[2];
  bit  m_ovf [2];
  bit  m_unf [2];
  int  m_snap[2];

  updown_counter_mod #(
    .WIDTH(W), .MODULUS(MOD),
    .SATURATE(0), .RESET_VALUE(0)
  ) u_wrap (
    .clk(clk), .resetb(resetb),
    .clear(clear), .en(en), .up(up),
    .load(load), .load_value(load_value),
    .flag_clr(flag_clr),
`ifdef UPDOWN_COUNTER_SNAPSHOT_EN
    .snap(snap), .snap_count(d_snap[0]),
`endif
    .count(d_cnt[0]), .tc(d_tc[0]),
    .wrap(d_wrap[0]), .ovf(d_ovf[0]),
    .unf(d_unf[0])
  );

  updown_counter_mod #(
    .WIDTH(W), .MODULUS(MOD),
    .SATURATE(1), .RESET_VALUE(0)
  ) u_sat (
    .clk(clk), .resetb(resetb),
    .clear(clear), .en(en), .up(up),
    .load(load), .load_value(load_value),
    .flag_clr(flag_clr),
`ifdef UPDOWN_COUNTER_SNAPSHOT_EN
    .snap(snap), .snap_count(d_snap[1]),
`endif
    .count(d_cnt[1]), .tc(d_tc[1]),
    .wrap(d_wrap[1]), .ovf(d_ovf[1]),
    .unf(d_unf[1])
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic int f_next(int c, bit sat);
    if (clear) return 0;
    if (load)
      return (int'(load_value) < MOD)
           ? int'(load_value) : MOD - 1;
    if (!en) return c;
    if (up)
      return sat ? ((c + 1 > MOD - 1) ? MOD - 1 : c + 1)
                 : (c + 1) % MOD;
    return sat ? ((c - 1 < 0) ? 0 : c - 1)
               : (c + MOD - 1) % MOD;
  endfunction

  function automatic bit f_evt(int c);
    if (clear || load || !en) return 0;
    return up ? (c == MOD - 1) : (c == 0);
  endfunction

  function automatic bit f_tc(int c);
    return en && ((up && c == MOD - 1)
               || (!up && c == 0));
  endfunction

  always @(posedge clk or negedge resetb) begin
    for (int s = 0; s < 2; s++) begin
      if (!resetb) begin
        m_cnt[s]  <= 0;
        m_wrap[s] <= 0;
        m_ovf[s]  <= 0;
        m_unf[s]  <= 0;
        m_snap[s] <= 0;
      end else begin
        m_cnt[s]  <= f_next(m_cnt[s], s == 1);
        m_wrap[s] <= f_evt(m_cnt[s]);
        m_ovf[s]  <= (f_evt(m_cnt[s]) && up)
                  || (m_ovf[s] && !flag_clr);
        m_unf[s]  <= (f_evt(m_cnt[s]) && !up)
                  || (m_unf[s] && !flag_clr);
        if (snap) m_snap[s] <= m_cnt[s];
      end
    end
  end

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int s = 0; s < 2; s++) begin
        chk($sformatf("count[%0d]", s),
            int'(d_cnt[s]), m_cnt[s]);
        chk($sformatf("tc[%0d]", s),
            int'(d_tc[s]), int'(f_tc(m_cnt[s])));
        chk($sformatf("wrap[%0d]", s),
            int'(d_wrap[s]), int'(m_wrap[s]));
        chk($sformatf("ovf[%0d]", s),
            int'(d_ovf[s]), int'(m_ovf[s]));
        chk($sformatf("unf[%0d]", s),
            int'(d_unf[s]), int'(m_unf[s]));
`ifdef UPDOWN_COUNTER_SNAPSHOT_EN
        chk($sformatf("snap[%0d]", s),
            int'(d_snap[s]), m_snap[s]);
`endif
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic idle();
    clear = 0; load = 0; en = 0;
    flag_clr = 0; snap = 0;
  endtask

  initial begin
    resetb = 0; up = 1; load_value = '0;
    idle();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_cnt", int'(d_cnt[0]), 0);
    chk("rst_wrap", int'(d_wrap[1]), 0);
    chk("rst_ovf", int'(d_ovf[0]), 0);
    resetb = 1;
    chk_on = 1;

    // count up through the limit
    en = 1; up = 1;
    cyc(9);
    chk("up_at9", int'(d_cnt[0]), 9);
    chk("up_tc9", int'(d_tc[0]), 1);
    cyc(1);
    chk("up_wrap0", int'(d_cnt[0]), 0);
    chk("up_wrapp", int'(d_wrap[0]), 1);
    chk("up_ovf", int'(d_ovf[0]), 1);
    chk("sat_hold9", int'(d_cnt[1]), 9);
    cyc(1);
    chk("up_wrap1cyc", int'(d_wrap[0]), 0);

    // count down through zero
    idle(); load = 1; load_value = 4'd2;
    cyc(1);
    load = 0; en = 1; up = 0;
    cyc(3);
    chk("dn_wrap9", int'(d_cnt[0]), 9);
    chk("dn_wrapp", int'(d_wrap[0]), 1);
    chk("dn_unf", int'(d_unf[0]), 1);
    chk("sat_hold0", int'(d_cnt[1]), 0);
    cyc(1);
    chk("dn_8", int'(d_cnt[0]), 8);

    // saturate at the top
    idle(); load = 1; load_value = 4'd9;
    cyc(1);
    load = 0; en = 1; up = 1;
    cyc(3);
    chk("sat_top", int'(d_cnt[1]), 9);
    chk("sat_wrapp", int'(d_wrap[1]), 1);
    chk("sat_ovf", int'(d_ovf[1]), 1);

    // priority and clamp
    clear = 1; load = 1; load_value = 4'd5;
    cyc(1);
    chk("clr_prio", int'(d_cnt[1]), 0);
    chk("clr_nowrap", int'(d_wrap[1]), 0);
    clear = 0; load_value = 4'd15;
    cyc(1);
    chk("ld_clamp", int'(d_cnt[0]), 9);
    chk("ld_nowrap", int'(d_wrap[0]), 0);
    idle(); flag_clr = 1;
    cyc(1);
    chk("fclr_ovf", int'(d_ovf[0]), 0);
    chk("fclr_unf", int'(d_unf[0]), 0);
    en = 1; up = 1;
    cyc(1);
    chk("set_wins", int'(d_ovf[0]), 1);
    chk("set_wins_s", int'(d_ovf[1]), 1);

`ifdef UPDOWN_COUNTER_SNAPSHOT_EN
    idle(); load = 1; load_value = 4'd3;
    cyc(1);
    load = 0; en = 1; up = 1;
    cyc(1);
    snap = 1;
    cyc(1);
    chk("snap_cnt5", int'(d_cnt[0]), 5);
    chk("snap_4", int'(d_snap[0]), 4);
    snap = 0;
    cyc(1);
    chk("snap_hold", int'(d_snap[0]), 4);
`endif

    // async reset mid-cycle
    idle(); load = 1; load_value = 4'd7;
    cyc(1);
    load = 0;
    #1 resetb = 0;
    #1;
    chk("arst_cnt", int'(d_cnt[0]), 0);
    chk("arst_ovf", int'(d_ovf[1]), 0);
    chk("arst_wrap", int'(d_wrap[1]), 0);
    resetb = 1;
    en = 1; up = 1;
    cyc(1);
    chk("arst_resume", int'(d_cnt[0]), 1);
    cyc(2);

    idle();
    cyc(1);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
